// File: rtl/sccb_cfg_master.sv
// SCCB (I2C-compatible) configuration master.
// Walks a synchronous config ROM and writes every entry to the sensor as a
// 3-phase write: DEV_ID, register address, register data. A ROM word equal to
// DELAY_MARK inserts a DELAY_CYC idle wait; END_MARK ends the table.
// SDA is open-drain: sda_oe=1 pulls the line low, sda_oe=0 releases it.
//
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   start          single-cycle start pulse (ignored while busy)
//   rom_addr       config ROM address
//   rom_data       {reg_addr, reg_data}, valid one clk after rom_addr changes
//   scl            SCCB clock (push-pull)
//   sda_o, sda_oe  SDA drive value (always 0) and pull-low enable
//   sda_i          SDA pad readback, sampled in the ACK bit
//   busy, done     run in progress / one-cycle end-of-table pulse
//   nack           sticky NACK flag, cleared by an accepted start
//   wr_count       register writes completed in this run
module sccb_cfg_master #(
  parameter int unsigned QUARTER_CYC = 250,
  parameter int unsigned ROM_AW      = 8,
  parameter logic [7:0]  DEV_ID      = 8'h42,
  parameter int unsigned DELAY_CYC   = 1_000_000,
  parameter logic [15:0] DELAY_MARK  = 16'hFFF0,
  parameter logic [15:0] END_MARK    = 16'hFFFF,
  parameter bit          ACK_CHECK   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              scl,
  output logic              sda_o,
  output logic              sda_oe,
  input  logic              sda_i,
  output logic              busy,
  output logic              done,
  output logic              nack,
  output logic [ROM_AW-1:0] wr_count
);

  localparam int unsigned QW = $clog2(QUARTER_CYC + 1);
  localparam int unsigned DW = $clog2(DELAY_CYC + 1);

  typedef enum logic [3:0] {
    IDLE, FETCH, DELAY, START, BIT, STOP, GAP, ADVANCE, FINISH
  } state_t;

  state_t        state, state_d;
  logic [QW-1:0] qcnt;     // clk count within a quarter
  logic [2:0]    qidx;     // quarter index within the current bus state / bit
  logic          fcnt;     // FETCH cycle 0/1
  logic [DW-1:0] dcnt;
  logic [3:0]    bitcnt;   // 0..7 data bits, 8 = ACK bit
  logic [1:0]    phase;    // 0 = device ID, 1 = register, 2 = data
  logic [23:0]   shift;
  logic          qwrap, bit_end;
  logic          scl_d, sda_oe_d;

  assign qwrap   = (qcnt == QW'(QUARTER_CYC - 1));
  assign bit_end = qwrap && (qidx == 3'd3);

  // Open-drain: the line is only ever pulled low, never driven high.
  assign sda_o = 1'b0;

  always_comb begin
    state_d  = state;
    scl_d    = 1'b1;
    sda_oe_d = 1'b0;
    unique case (state)
      IDLE:    if (start) state_d = FETCH;
      FETCH: begin
        if (fcnt) begin
          if (rom_data == END_MARK)        state_d = FINISH;
          else if (rom_data == DELAY_MARK) state_d = DELAY;
          else                             state_d = START;
        end
      end
      DELAY:   if (dcnt == DW'(DELAY_CYC - 1)) state_d = ADVANCE;
      START: begin
        scl_d    = (qidx < 3'd2);
        sda_oe_d = 1'b1;
        if (bit_end) state_d = BIT;
      end
      BIT: begin
        scl_d    = (qidx == 3'd1) || (qidx == 3'd2);
        sda_oe_d = (bitcnt != 4'd8) && !shift[23];
        if (bit_end && bitcnt == 4'd8 && phase == 2'd2) state_d = STOP;
      end
      STOP: begin
        scl_d    = (qidx != 3'd0);
        sda_oe_d = (qidx < 3'd3);
        if (qwrap && qidx == 3'd4) state_d = GAP;
      end
      GAP:     if (qwrap && qidx == 3'd1) state_d = ADVANCE;
      ADVANCE: state_d = (rom_addr == '1) ? FINISH : FETCH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      qcnt     <= '0;
      qidx     <= '0;
      fcnt     <= 1'b0;
      dcnt     <= '0;
      bitcnt   <= '0;
      phase    <= '0;
      shift    <= '0;
      rom_addr <= '0;
      wr_count <= '0;
      scl      <= 1'b1;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      nack     <= 1'b0;
    end else begin
      state  <= state_d;
      scl    <= scl_d;
      sda_oe <= sda_oe_d;
      done   <= 1'b0;

      // All timing counters restart whenever the state changes; inside BIT
      // the quarter index wraps every 4 quarters to frame consecutive bits.
      if (state_d != state) begin
        qcnt <= '0;
        qidx <= '0;
        fcnt <= 1'b0;
        dcnt <= '0;
      end else begin
        fcnt <= 1'b1;
        dcnt <= dcnt + DW'(1);
        if (qwrap) begin
          qcnt <= '0;
          qidx <= (state == BIT && qidx == 3'd3) ? 3'd0 : qidx + 3'd1;
        end else begin
          qcnt <= qcnt + QW'(1);
        end
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            nack     <= 1'b0;
            wr_count <= '0;
            rom_addr <= '0;
          end
        end
        FETCH:   if (fcnt) shift <= {DEV_ID, rom_data};
        START: begin
          bitcnt <= '0;
          phase  <= '0;
        end
        BIT: begin
          if (ACK_CHECK && bitcnt == 4'd8 && qidx == 3'd1 && qwrap && sda_i)
            nack <= 1'b1;
          if (bit_end) begin
            if (bitcnt == 4'd8) begin
              bitcnt <= '0;
              phase  <= phase + 2'd1;
            end else begin
              bitcnt <= bitcnt + 4'd1;
              shift  <= {shift[22:0], 1'b0};
            end
          end
        end
        STOP:    if (qwrap && qidx == 3'd4) wr_count <= wr_count + ROM_AW'(1);
        ADVANCE: if (rom_addr != '1) rom_addr <= rom_addr + ROM_AW'(1);
        FINISH: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_cfg_master.sv
// Bench for sccb_cfg_master. dut0 (ACK checking on) talks to a behavioural
// sensor/bus decoder; expected writes and end-of-run results are queued from
// a table-walk model of the ROM and compared by the monitor as they appear.
// dut1 (ACK checking off) runs against a bus nobody acknowledges.
module tb_sccb_cfg_master;

  localparam int unsigned QC    = 4;
  localparam int unsigned AW    = 2;
  localparam int unsigned DLY   = 50;
  localparam logic [15:0] DMARK = 16'hFFF0;
  localparam logic [15:0] EMARK = 16'hFFFF;
  localparam logic [7:0]  DEV   = 8'h42;
  localparam int unsigned NOMAX = 32'hFFFF_FFFF;

  typedef struct {
    logic [15:0] word;
    logic [2:0]  nm;       // bit p set: sensor NACKs phase p
    int unsigned min_gap;
    int unsigned max_gap;
  } wr_t;

  typedef struct {
    logic [AW-1:0] wrc;
    logic          nack;
    logic [AW-1:0] addr;
  } run_t;

  logic clk = 1'b0;
  logic reset, start0, start1;
  logic [AW-1:0] rom_addr0, rom_addr1, wr_count0, wr_count1;
  logic [15:0]   rom_data0, rom_data1;
  logic scl0, sda_o0, sda_oe0, sda_i0, busy0, done0, nack0;
  logic scl1, sda_o1, sda_oe1, sda_i1, busy1, done1, nack1;
  logic pull, sda_bus;
  logic [15:0] rom [4];
  logic [2:0]  nm_tab [4];
  wr_t  exp_q [$];
  run_t run_q [$];
  int   checks = 0;
  int   failures = 0;
  int   mon_nbytes = 0;
  int   mon_bitn = 0;

  always #5 clk = ~clk;

  sccb_cfg_master #(.QUARTER_CYC(QC), .ROM_AW(AW), .DEV_ID(DEV), .DELAY_CYC(DLY),
                    .DELAY_MARK(DMARK), .END_MARK(EMARK), .ACK_CHECK(1'b1)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .rom_addr(rom_addr0), .rom_data(rom_data0),
    .scl(scl0), .sda_o(sda_o0), .sda_oe(sda_oe0), .sda_i(sda_i0),
    .busy(busy0), .done(done0), .nack(nack0), .wr_count(wr_count0));

  sccb_cfg_master #(.QUARTER_CYC(QC), .ROM_AW(AW), .DEV_ID(DEV), .DELAY_CYC(DLY),
                    .DELAY_MARK(DMARK), .END_MARK(EMARK), .ACK_CHECK(1'b0)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .rom_addr(rom_addr1), .rom_data(rom_data1),
    .scl(scl1), .sda_o(sda_o1), .sda_oe(sda_oe1), .sda_i(sda_i1),
    .busy(busy1), .done(done1), .nack(nack1), .wr_count(wr_count1));

  always_ff @(posedge clk) begin
    rom_data0 <= rom[rom_addr0];
    rom_data1 <= rom[rom_addr1];
  end

  assign sda_bus = ~sda_oe0 & ~pull;
  assign sda_i0  = sda_bus;
  assign sda_i1  = ~sda_oe1;   // pull-up only: every ACK slot reads as NACK

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [15:0] rnd_word();
    return 16'($urandom_range(0, 32'hFFEF));
  endfunction

  task automatic set_rom(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d);
    rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
    for (int i = 0; i < 4; i++) nm_tab[i] = '0;
  endtask

  // Reference walk of the table: which writes appear, which idle gaps they
  // need, and how the run ends.
  task automatic plan_run();
    int unsigned a = 0;
    int unsigned writes = 0;
    logic sticky = 1'b0;
    bit dly = 1'b0;
    bit first = 1'b1;
    wr_t e;
    run_t r;
    forever begin
      if (rom[a] == EMARK) break;
      if (rom[a] == DMARK) begin
        dly = 1'b1;
      end else begin
        e.word    = rom[a];
        e.nm      = nm_tab[a];
        e.min_gap = dly ? DLY : 0;
        e.max_gap = (first || dly) ? NOMAX : DLY - 1;
        exp_q.push_back(e);
        writes++;
        sticky = sticky | (nm_tab[a] != 3'b000);
        dly = 1'b0;
        first = 1'b0;
      end
      if (a == 3) break;
      a++;
    end
    r.wrc  = AW'(writes);
    r.nack = sticky;
    r.addr = AW'(a);
    run_q.push_back(r);
  endtask

  task automatic pulse_start0();
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
  endtask

  task automatic wait_done0(input string tag);
    int unsigned n = 0;
    bit got = 1'b0;
    while (!got && n < 4000) begin
      @(negedge clk);
      n++;
      if (done0) got = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
  endtask

  // Bus decoder, sensor and scoreboard consumer for dut0.
  initial begin : monitor
    logic sda_now, pscl, psda, pdone, in_xfer;
    logic [7:0] sh, got0, got1, got2;
    logic [2:0] cur_nm;
    int bitn, nbytes;
    int unsigned idle_cnt;
    wr_t e;
    run_t r;
    pull = 1'b0; pscl = 1'b1; psda = 1'b1; pdone = 1'b0; in_xfer = 1'b0;
    sh = '0; got0 = '0; got1 = '0; got2 = '0; cur_nm = '0;
    bitn = 0; nbytes = 0; idle_cnt = 0;
    forever begin
      @(negedge clk);
      sda_now = sda_bus;
      if (reset) begin
        pull = 1'b0; in_xfer = 1'b0; bitn = 0; nbytes = 0; idle_cnt = 0;
        pscl = 1'b1; psda = 1'b1; pdone = 1'b0;
      end else begin
        if (pdone) chk("done_one_cycle", 32'(done0), 32'd0);
        if (done0) begin
          chk("run_expected", 32'(run_q.size() > 0), 32'd1);
          chk("writes_left_at_done", 32'(exp_q.size()), 32'd0);
          chk("busy_low_at_done", 32'(busy0), 32'd0);
          if (run_q.size() > 0) begin
            r = run_q.pop_front();
            chk("wr_count", 32'(wr_count0), 32'(r.wrc));
            chk("nack", 32'(nack0), 32'(r.nack));
            chk("rom_addr_final", 32'(rom_addr0), 32'(r.addr));
          end
        end
        pdone = done0;

        if (pscl && scl0 && psda && !sda_now) begin
          chk("start_not_repeated", 32'(in_xfer), 32'd0);
          if (exp_q.size() > 0) begin
            if (exp_q[0].min_gap > 0)
              chk("gap_min", 32'(idle_cnt >= exp_q[0].min_gap), 32'd1);
            if (exp_q[0].max_gap != NOMAX)
              chk("gap_max", 32'(idle_cnt <= exp_q[0].max_gap), 32'd1);
            cur_nm = exp_q[0].nm;
          end else begin
            cur_nm = '0;
          end
          in_xfer = 1'b1; bitn = 0; nbytes = 0;
        end else if (pscl && scl0 && !psda && sda_now && in_xfer) begin
          chk("write_expected", 32'(exp_q.size() > 0), 32'd1);
          chk("bytes_per_write", 32'(nbytes), 32'd3);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("dev_id", 32'(got0), 32'(DEV));
            chk("reg_addr", 32'(got1), 32'(e.word[15:8]));
            chk("reg_data", 32'(got2), 32'(e.word[7:0]));
          end
          in_xfer = 1'b0;
        end else if (!pscl && scl0 && in_xfer) begin
          if (bitn < 8) begin
            sh = {sh[6:0], sda_now};
            bitn++;
          end else begin
            chk("ack_slot_released", 32'(sda_oe0), 32'd0);
            case (nbytes)
              0: got0 = sh;
              1: got1 = sh;
              2: got2 = sh;
              default: ;
            endcase
            nbytes++;
            bitn = 0;
          end
        end else if (pscl && !scl0 && in_xfer) begin
          pull = (bitn == 8) && (nbytes < 3) && (((cur_nm >> nbytes) & 3'b001) == 3'b000);
        end

        if (scl0 && !sda_oe0) idle_cnt++;
        else idle_cnt = 0;
        pscl = scl0;
        psda = sda_now;
      end
      mon_nbytes = nbytes;
      mon_bitn = bitn;
    end
  end

  initial begin : stim
    int unsigned n;
    int unsigned k;
    bit got;
    reset = 1'b1; start0 = 1'b0; start1 = 1'b0;
    set_rom(EMARK, EMARK, EMARK, EMARK);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_scl", 32'(scl0), 32'd1);
    chk("rst_sda_oe", 32'(sda_oe0), 32'd0);
    chk("rst_sda_o", 32'(sda_o0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_nack", 32'(nack0), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr0), 32'd0);
    chk("rst_wr_count", 32'(wr_count0), 32'd0);

    // Single write then end of table.
    set_rom(16'h1280, EMARK, EMARK, EMARK);
    plan_run(); pulse_start0(); wait_done0("single");

    // Two writes separated by a delay marker.
    set_rom(16'h1214, DMARK, 16'h1180, EMARK);
    plan_run(); pulse_start0(); wait_done0("delay");

    // NACK on the data phase of the first write; the rest still completes.
    set_rom(rnd_word(), rnd_word(), rnd_word(), EMARK);
    nm_tab[0] = 3'b100;
    plan_run(); pulse_start0(); wait_done0("nack");
    repeat (10) @(negedge clk);
    chk("nack_sticky", 32'(nack0), 32'd1);

    // Full table without markers: no address wrap; a new start clears nack;
    // a second start while busy is ignored.
    set_rom(rnd_word(), rnd_word(), rnd_word(), rnd_word());
    plan_run(); pulse_start0();
    chk("nack_cleared_by_start", 32'(nack0), 32'd0);
    chk("busy_after_start", 32'(busy0), 32'd1);
    repeat (300) @(negedge clk);
    chk("busy_mid_run", 32'(busy0), 32'd1);
    pulse_start0();
    wait_done0("full");

    // Randomised tables and NACK patterns.
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 4; i++) begin
        k = $urandom_range(0, 5);
        rom[i] = (k == 0) ? EMARK : (k == 1) ? DMARK : rnd_word();
        nm_tab[i] = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      end
      plan_run(); pulse_start0(); wait_done0("random");
    end

    // Reset during bit 5 of the register-address phase.
    set_rom(rnd_word(), rnd_word(), EMARK, EMARK);
    plan_run(); pulse_start0();
    n = 0;
    while (!(mon_nbytes == 1 && mon_bitn == 5) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("reached_phase2_bit5", 32'(mon_nbytes == 1 && mon_bitn == 5), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_scl", 32'(scl0), 32'd1);
    chk("abort_sda_oe", 32'(sda_oe0), 32'd0);
    chk("abort_busy", 32'(busy0), 32'd0);
    chk("abort_rom_addr", 32'(rom_addr0), 32'd0);
    exp_q.delete();
    run_q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_stays_idle", 32'(busy0), 32'd0);
    plan_run(); pulse_start0(); wait_done0("restart");

    // Start coincident with reset: reset wins.
    @(negedge clk); reset = 1'b1; start0 = 1'b1;
    @(negedge clk); reset = 1'b0; start0 = 1'b0;
    chk("start_with_reset_busy", 32'(busy0), 32'd0);
    repeat (30) @(negedge clk);
    chk("start_with_reset_idle", 32'(busy0), 32'd0);
    chk("start_with_reset_addr", 32'(rom_addr0), 32'd0);

    // ACK checking disabled: unacknowledged writes leave nack low.
    set_rom(rnd_word(), rnd_word(), EMARK, EMARK);
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    n = 0; got = 1'b0;
    while (!got && n < 4000) begin
      @(negedge clk);
      n++;
      if (done1) got = 1'b1;
    end
    chk("noack_done_seen", 32'(got), 32'd1);
    chk("noack_nack", 32'(nack1), 32'd0);
    chk("noack_wr_count", 32'(wr_count1), 32'd2);
    chk("noack_rom_addr", 32'(rom_addr1), 32'd2);
    chk("noack_busy", 32'(busy1), 32'd0);
    chk("noack_scl", 32'(scl1), 32'd1);
    chk("noack_sda_o", 32'(sda_o1), 32'd0);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
